esd_host_supervisor: RTL and testbench



---
 rtl/esd_host_supervisor.sv | 159 +++++++++++++++
 tb/tb_esd_host_supervisor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esd_host_supervisor.sv
// Host-side supervisor for the emergency-shutdown controller.
// Generates the watchdog heartbeat and sequences bounded ACK restarts.
module esd_host_supervisor #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int KICK_MS        = 10,
    parameter int ACK_LOW_CYCLES = 100,
    parameter int CONFIRM_CYCLES = 1000,
    parameter int HOLDOFF_CYCLES = 500,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       restart_req,
    input  logic       shutdown_in,
    output logic       wdg_kick,
    output logic       ack_n,
    output logic       running,
    output logic       lockout,
    output logic       trip,
    output logic [1:0] retries
);

    localparam int KICK_CYCLES = CLK_HZ / 1000 * KICK_MS;
    localparam int KW = $clog2(KICK_CYCLES);
    localparam int CM1 = (ACK_LOW_CYCLES > CONFIRM_CYCLES) ?
                         ACK_LOW_CYCLES : CONFIRM_CYCLES;
    localparam int CMAX = (CM1 > HOLDOFF_CYCLES) ? CM1 : HOLDOFF_CYCLES;
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [KW-1:0] KICK_LAST = KW'(KICK_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_LOW_CYCLES - 1);
    localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_OFF,
        S_ARM,
        S_ACK_LOW,
        S_CONFIRM,
        S_HOLDOFF,
        S_RUN,
        S_LOCKOUT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    retries_next;
    logic          sync1;
    logic          sd_s;
    logic [CW-1:0] cnt;
    logic [KW-1:0] kcnt;
    logic          hb_now;
    logic          hb_next;
    logic          timed;

    assign hb_now  = (state != S_OFF) && (state != S_LOCKOUT);
    assign hb_next = (state_next != S_OFF) && (state_next != S_LOCKOUT);
    assign timed   = (state == S_ACK_LOW) || (state == S_CONFIRM) ||
                     (state == S_HOLDOFF);

    // Two-flop synchroniser; shutdown presumed until observed clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sd_s  <= 1'b1;
        end else begin
            sync1 <= shutdown_in;
            sd_s  <= sync1;
        end
    end

    // Next-state and retry bookkeeping; disable overrides everything.
    always_comb begin
        state_next   = state;
        retries_next = retries;
        if (!enable) begin
            state_next = S_OFF;
        end else begin
            unique case (state)
                S_OFF: state_next = S_ARM;
                S_ARM: begin
                    if (!sd_s) begin
                        state_next = S_RUN;
                    end else if (restart_req) begin
                        state_next   = S_ACK_LOW;
                        retries_next = 2'd0;
                    end
                end
                S_ACK_LOW: begin
                    if (cnt == ACK_LAST) state_next = S_CONFIRM;
                end
                S_CONFIRM: begin
                    if (!sd_s) begin
                        state_next = S_RUN;
                    end else if (cnt == CONF_LAST) begin
                        if (retries != RETRY_MAX)
                            retries_next = retries + 2'd1;
                        state_next = (retries_next == RETRY_MAX) ?
                                     S_LOCKOUT : S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt == HOLD_LAST) state_next = S_ACK_LOW;
                end
                S_RUN: begin
                    if (sd_s) state_next = S_ARM;
                end
                S_LOCKOUT: state_next = S_LOCKOUT;
                default:   state_next = S_OFF;
            endcase
        end
    end

    // Phase timer restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (timed) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Heartbeat phase counter, free-running across heartbeat states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kcnt <= '0;
        end else if (!hb_next) begin
            kcnt <= '0;
        end else if (hb_now) begin
            kcnt <= (kcnt == KICK_LAST) ? '0 : kcnt + 1'b1;
        end
    end

    // State register and outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_OFF;
            retries  <= 2'd0;
            wdg_kick <= 1'b0;
            ack_n    <= 1'b1;
            running  <= 1'b0;
            lockout  <= 1'b0;
            trip     <= 1'b0;
        end else begin
            state    <= state_next;
            retries  <= retries_next;
            wdg_kick <= hb_now && hb_next && (kcnt == KICK_LAST);
            ack_n    <= (state_next != S_ACK_LOW);
            running  <= (state_next == S_RUN);
            lockout  <= (state_next == S_LOCKOUT);
            trip     <= (state == S_RUN) && (state_next == S_ARM);
        end
    end

endmodule

// File: tb/tb_esd_host_supervisor.sv
// Scoreboard bench for esd_host_supervisor.
// Expected events are queued by stimulus; a monitor checks DUT activity.
module tb_esd_host_supervisor;

    localparam int K   = 1000;
    localparam int A   = 100;
    localparam int C   = 1000;
    localparam int H   = 500;
    localparam int P   = A + C + H;
    localparam int INF = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       restart_req = 1'b0;
    logic       shutdown_in = 1'b1;
    logic       wdg_kick;
    logic       ack_n;
    logic       running;
    logic       lockout;
    logic       trip;
    logic [1:0] retries;

    esd_host_supervisor #(
        .CLK_HZ(1_000_000),
        .KICK_MS(1),
        .ACK_LOW_CYCLES(A),
        .CONFIRM_CYCLES(C),
        .HOLDOFF_CYCLES(H),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .restart_req(restart_req),
        .shutdown_in(shutdown_in),
        .wdg_kick(wdg_kick),
        .ack_n(ack_n),
        .running(running),
        .lockout(lockout),
        .trip(trip),
        .retries(retries)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    int  kick_q[$];
    int  trip_q[$];
    ev_t ack_q[$];
    ev_t run_q[$];
    ev_t lock_q[$];
    ev_t ret_q[$];

    int cyc = 0;
    int hb_origin = 0;
    int hb_stop = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;

    logic       p_ack;
    logic       p_run;
    logic       p_lock;
    logic [1:0] p_ret;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic edge_chk(input string nm, input ev_t e,
                            input logic [31:0] v);
        n_chk++;
        if (e.cyc != cyc || v !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %0d at cycle %0d, expected %0d at %0d",
                     nm, v, cyc, e.val, e.cyc);
        end
    endtask

    task automatic unexp(input string nm, input logic [31:0] v);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected value %0d at cycle %0d", nm, v, cyc);
    endtask

    // Reference heartbeat: kicks every K cycles after heartbeat origin.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc > hb_origin && cyc < hb_stop &&
            (cyc - hb_origin) % K == 0)
            kick_q.push_back(cyc);
    end

    // Monitor: every pulse or output change must match a queued event.
    always @(negedge clk) begin
        if (mon_on) begin
            if (wdg_kick !== 1'b0) begin
                if (kick_q.size() == 0) unexp("wdg_kick", 32'(wdg_kick));
                else chk("wdg_kick_cycle", cyc, kick_q.pop_front());
            end
            if (trip !== 1'b0) begin
                if (trip_q.size() == 0) unexp("trip", 32'(trip));
                else chk("trip_cycle", cyc, trip_q.pop_front());
            end
            if (ack_n !== p_ack) begin
                p_ack = ack_n;
                if (ack_q.size() == 0) unexp("ack_n", 32'(ack_n));
                else edge_chk("ack_n", ack_q.pop_front(), 32'(ack_n));
            end
            if (running !== p_run) begin
                p_run = running;
                if (run_q.size() == 0) unexp("running", 32'(running));
                else edge_chk("running", run_q.pop_front(), 32'(running));
            end
            if (lockout !== p_lock) begin
                p_lock = lockout;
                if (lock_q.size() == 0) unexp("lockout", 32'(lockout));
                else edge_chk("lockout", lock_q.pop_front(), 32'(lockout));
            end
            if (retries !== p_ret) begin
                p_ret = retries;
                if (ret_q.size() == 0) unexp("retries", 32'(retries));
                else edge_chk("retries", ret_q.pop_front(), 32'(retries));
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_req();
        restart_req = 1'b1;
        @(posedge clk);
        #1;
        restart_req = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_kick"}, 32'(wdg_kick), 0);
        chk({tag, "_ack_n"}, 32'(ack_n), 1);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_lockout"}, 32'(lockout), 0);
        chk({tag, "_trip"}, 32'(trip), 0);
        chk({tag, "_retries"}, 32'(retries), 0);
    endtask

    initial begin
        int q;
        int x;
        int y;
        int a;
        int c;
        int lk;

        // Power-on reset with enable and shutdown asserted.
        repeat (5) @(posedge clk);
        #1;
        reset_checks("por");
        p_ack = 1'b1;
        p_run = 1'b0;
        p_lock = 1'b0;
        p_ret = 2'd0;
        mon_on = 1'b1;
        hb_origin = cyc + 1;
        hb_stop = INF;
        rst_n = 1'b1;
        wait_until(cyc + 2500 + int'($urandom_range(0, 400)));

        // Successful restart: shutdown clears 50 cycles after ACK release.
        q = cyc;
        ack_q.push_back('{q + 1, 0});
        ack_q.push_back('{q + 1 + A, 1});
        pulse_req();
        wait_until(q + 1 + A + 50);
        shutdown_in = 1'b0;
        run_q.push_back('{cyc + 3, 1});
        wait_until(cyc + 3);
        chk("retries_after_run", 32'(retries), 0);

        // Trip from RUN: single trip pulse, no automatic restart.
        wait_until(cyc + int'($urandom_range(20, 600)));
        y = cyc;
        shutdown_in = 1'b1;
        run_q.push_back('{y + 3, 0});
        trip_q.push_back(y + 3);
        wait_until(y + 3 + int'($urandom_range(1200, 1800)));
        chk("ack_idle_after_trip", 32'(ack_n), 1);

        // Stuck shutdown: three attempts then lockout.
        q = cyc;
        for (int i = 0; i < 3; i++) begin
            ack_q.push_back('{q + 1 + i * P, 0});
            ack_q.push_back('{q + 1 + i * P + A, 1});
            ret_q.push_back('{q + 1 + i * P + A + C, i + 1});
        end
        lk = q + 1 + 2 * P + A + C;
        lock_q.push_back('{lk, 1});
        hb_stop = lk;
        pulse_req();
        wait_until(lk + 1);
        chk("lockout_set", 32'(lockout), 1);
        chk("retries_max", 32'(retries), 3);
        wait_until(lk + 1500);
        pulse_req();
        wait_until(cyc + 300);
        chk("lockout_hold", 32'(lockout), 1);

        // Reset in lockout returns everything to reset values.
        a = cyc;
        rst_n = 1'b0;
        lock_q.push_back('{a + 1, 0});
        ret_q.push_back('{a + 1, 0});
        wait_until(a + 3);
        reset_checks("mid_rst");
        wait_until(a + 5);
        hb_origin = cyc + 1;
        hb_stop = INF;
        rst_n = 1'b1;
        wait_until(cyc + 2200 + int'($urandom_range(0, 300)));

        // Disable mid-ACK_LOW exactly when a kick is due.
        c = hb_origin + K * ((cyc + 100 - hb_origin) / K + 1);
        wait_until(c - 60);
        q = cyc;
        ack_q.push_back('{q + 1, 0});
        ack_q.push_back('{c, 1});
        pulse_req();
        wait_until(c - 1);
        enable = 1'b0;
        hb_stop = c;
        wait_until(c + int'($urandom_range(10, 400)));
        chk("off_ack_n", 32'(ack_n), 1);
        enable = 1'b1;
        hb_origin = cyc + 1;
        hb_stop = INF;
        wait_until(cyc + 1100 + int'($urandom_range(0, 300)));

        // Disable on the same cycle sd_s rises in RUN: no trip.
        q = cyc;
        ack_q.push_back('{q + 1, 0});
        ack_q.push_back('{q + 1 + A, 1});
        pulse_req();
        x = q + 1 + A + int'($urandom_range(0, 900));
        wait_until(x);
        shutdown_in = 1'b0;
        run_q.push_back('{x + 3, 1});
        wait_until(x + 3 + int'($urandom_range(10, 300)));
        y = cyc;
        shutdown_in = 1'b1;
        run_q.push_back('{y + 3, 0});
        wait_until(y + 2);
        enable = 1'b0;
        hb_stop = y + 3;
        wait_until(y + 50);
        enable = 1'b1;
        hb_origin = cyc + 1;
        hb_stop = INF;
        wait_until(cyc + 2100);

        // Every queued expectation must have been consumed.
        chk("kick_q_left", kick_q.size(), 0);
        chk("trip_q_left", trip_q.size(), 0);
        chk("ack_q_left", ack_q.size(), 0);
        chk("run_q_left", run_q.size(), 0);
        chk("lock_q_left", lock_q.size(), 0);
        chk("ret_q_left", ret_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
